wallace_final_cpa: RTL
======================

WALLACE_FINAL_CPA -- requirements
Module: wallace_final_cpa

Interface
REQ-001 Parameter WIDTH, default 64: width of the sum/carry vectors and of the product.
REQ-002 Parameter SLICE, default 16: bits added per cycle; WIDTH SHALL be an integer multiple of SLICE.
REQ-003 Parameter TAG_W, default 4: width of the reservation-station tag carried with each operation.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  sum_vec, carry_vec and in_tag are valid.
REQ-007 in_ready  output  1  block can accept an operation.
REQ-008 sum_vec  input  WIDTH  sum row from the last Wallace CSA level.
REQ-009 carry_vec  input  WIDTH  carry row from the last Wallace CSA level, already left-shifted, bit 0 normally 0.
REQ-010 in_tag  input  TAG_W  issuing reservation-station tag.
REQ-011 flush  input  1  squash any in-flight operation.
REQ-012 out_valid  output  1  product and out_tag are valid.
REQ-013 out_ready  input  1  consumer (CDB arbiter) accepts the result.
REQ-014 product  output  WIDTH  (sum_vec + carry_vec) mod 2^WIDTH.
REQ-015 out_tag  output  TAG_W  tag of the returned product.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ADD, DONE.
REQ-017 in_ready SHALL be 1 in IDLE only; acceptance = in_valid & in_ready at a rising edge.
REQ-018 On acceptance, the block SHALL capture sum_vec, carry_vec and in_tag, clear slice index and carry-in, and enter ADD.
REQ-019 In ADD, each cycle SHALL add slice k of both operands plus the registered carry, write the result into product bits [k*SLICE +: SLICE], register carry-out, and increment k.
REQ-020 After slice WIDTH/SLICE-1 (4 cycles at defaults) the FSM SHALL enter DONE; out_valid SHALL be high exactly 4 edges after the acceptance edge at defaults.
REQ-021 The final carry-out of the top slice SHALL be discarded.
REQ-022 In DONE, out_valid=1 and product/out_tag SHALL be held stable until out_valid & out_ready at an edge, then return to IDLE.
REQ-023 out_valid SHALL be 0 in IDLE and ADD; product SHALL not be treated as valid there.
REQ-024 in_valid is ignored outside IDLE; a new operation is accepted no earlier than the edge after the DONE handshake (one bubble minimum).
REQ-025 flush=1 at an edge SHALL force IDLE from any state, dropping any pending result, with priority over acceptance and over the output handshake in the same cycle.
REQ-026 Operand inputs SHALL not be sampled after the acceptance edge; later changes have no effect.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, and clear out_valid, product, out_tag, slice index and carry register to 0, with priority over flush and all handshakes.
REQ-028 Reset during ADD or DONE SHALL abandon the operation; no out_valid pulse SHALL follow.
REQ-029 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-030 A shared package SHALL hold WIDTH, SLICE and TAG_W defaults and the FSM state encoding (IDLE=2'd0, ADD=2'd1, DONE=2'd2).
REQ-031 The per-cycle adder SHALL be one sub-module, cpa_slice, SLICE-bit with cin/cout, instantiated once and reused every ADD cycle.

Verification
REQ-032 sum=0x0000_0000_FFFF_FFFF, carry=0x0000_0000_0000_0001, tag=3, out_ready=1 -> out_valid 4 edges after acceptance, product=0x0000_0001_0000_0000, out_tag=3.
REQ-033 sum=0xFFFF_FFFF_FFFF_FFFF, carry=0x1 -> product=0x0 (carry ripples through all four slices, top carry dropped).
REQ-034 sum=0xFFFF_FFFE_0000_0000, carry=0x0000_0000_0000_0001 (0xFFFFFFFF squared) -> product=0xFFFF_FFFE_0000_0001; out_ready held low 5 cycles -> out_valid, product, out_tag stable throughout, single handshake on release.
REQ-035 flush asserted in 2nd ADD cycle with in_valid=1 same cycle -> IDLE next edge, no acceptance, no out_valid; next operation completes correctly.
REQ-036 rst asserted in DONE with out_ready=1 -> no handshake, all outputs 0, in_ready=1 after release.
REQ-037 in_valid held high for 3 back-to-back operations with out_ready=1 -> each result correct and in order, acceptances spaced 6 cycles apart.

Source files
------------

// File: rtl/wallace_final_cpa_pkg.sv
// wallace_final_cpa_pkg: shared defaults and FSM encoding for the sliced final carry-propagate adder.
package wallace_final_cpa_pkg;
   localparam int WIDTH_DEF = 64;
   localparam int SLICE_DEF = 16;
   localparam int TAG_W_DEF = 4;
   typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/wallace_final_cpa_cpa_slice.sv
// cpa_slice: SLICE-bit ripple adder with carry in/out, reused once per ADD cycle.
module cpa_slice
   import wallace_final_cpa_pkg::*;
#(
   parameter int SLICE = SLICE_DEF
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] s,
   output logic             cout
);
   assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
endmodule

// File: rtl/wallace_final_cpa.sv
// wallace_final_cpa: adds the final Wallace sum/carry rows SLICE bits per cycle,
// returning the tagged product through a valid/ready handshake.
module wallace_final_cpa
   import wallace_final_cpa_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SLICE = SLICE_DEF,
   parameter int TAG_W = TAG_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] sum_vec,
   input  logic [WIDTH-1:0] carry_vec,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] product,
   output logic [TAG_W-1:0] out_tag
);
   localparam int NS = WIDTH / SLICE;
   localparam int KW = NS > 1 ? $clog2(NS) : 1;
   localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
   localparam logic [KW-1:0] LAST = KW'(NS - 1);
   state_t state, state_nx;
   logic [WIDTH-1:0] a_q, b_q;
   logic [KW-1:0] k;
   logic [IW-1:0] base;
   logic [SLICE-1:0] s;
   logic cin, cout, acc;
   assign base = IW'(k) * IW'(SLICE);
   assign acc = in_valid & in_ready & ~flush;
   cpa_slice #(.SLICE(SLICE)) u_slice (
      .a(a_q[base +: SLICE]),
      .b(b_q[base +: SLICE]),
      .cin(cin),
      .s(s),
      .cout(cout)
   );
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= state_nx;
   always_comb
      state_nx = flush ? IDLE
               : state == IDLE ? (in_valid ? ADD : IDLE)
               : state == ADD  ? (k == LAST ? DONE : ADD)
               : state == DONE ? (out_ready ? IDLE : DONE)
               : IDLE;
   always_comb begin
      in_ready  = state == IDLE;
      out_valid = state == DONE;
   end
   // The carry out of the top slice lands in cin and is simply never used.
   always_ff @(posedge clk)
      if (rst) begin
         product <= '0;
         out_tag <= '0;
         k       <= '0;
         cin     <= 1'b0;
      end else if (acc) begin
         a_q     <= sum_vec;
         b_q     <= carry_vec;
         out_tag <= in_tag;
         k       <= '0;
         cin     <= 1'b0;
      end else if (state == ADD) begin
         product[base +: SLICE] <= s;
         cin <= cout;
         k   <= k + KW'(1);
      end
endmodule
